// File: rtl/adi2axis_capture_seq.sv
// ---------------------------------------------------------------------------
// adi2axis_capture_seq
// Control sequencer for the adi2axis ADC-to-AXI-Stream capture converter.
// Runs N back-to-back fixed-length capture bursts separated by a programmable
// gap. Before re-arming, it waits for both the converter's done flag and DMA
// completion. It also counts overflow cycles, runs a per-burst watchdog and
// reports status and an interrupt.
//
// Ports:
//   AXIS_ACLK, AXIS_ARESET    clock, asynchronous active-high reset
//   cfg_enable                run level: rising edge starts, low aborts/acks
//   cfg_num_bytes/_num_bursts/_gap_cycles/_timeout   run configuration
//   conv_ctrl, conv_num_bytes converter control (0 = clear/stop, 1 = start)
//   conv_stat                 converter status (bit0 capture_en, bit1 done)
//   conv_ovf, dma_cmplt       converter overflow level, DMA completion pulse
//   busy, irq                 run in progress, entry pulse on DONE/ERROR
//   bursts_done, ovf_count    run counters
//   status                    {bursts_done, 10'b0, err_cfg, err_timeout,
//                             busy, state}
// ---------------------------------------------------------------------------
module adi2axis_capture_seq #(
    parameter int unsigned C_BYTES    = 8,
    parameter int unsigned CLR_CYCLES = 4
) (
    input  logic        AXIS_ACLK,
    input  logic        AXIS_ARESET,
    input  logic        cfg_enable,
    input  logic [31:0] cfg_num_bytes,
    input  logic [15:0] cfg_num_bursts,
    input  logic [15:0] cfg_gap_cycles,
    input  logic [31:0] cfg_timeout,
    output logic [31:0] conv_ctrl,
    output logic [31:0] conv_num_bytes,
    input  logic [31:0] conv_stat,
    input  logic        conv_ovf,
    input  logic        dma_cmplt,
    output logic        busy,
    output logic        irq,
    output logic [15:0] bursts_done,
    output logic [15:0] ovf_count,
    output logic [31:0] status
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CLEAR   = 3'd1,
        S_ARM     = 3'd2,
        S_CAPTURE = 3'd3,
        S_DRAIN   = 3'd4,
        S_GAP     = 3'd5,
        S_DONE    = 3'd6,
        S_ERROR   = 3'd7
    } state_t;

    localparam logic [15:0] CLR_LEN = 16'(CLR_CYCLES);

    state_t      state_q, state_d;
    logic        en_prev_q;
    logic [31:0] nb_q, nb_d;
    logic [15:0] nbursts_q, nbursts_d;
    logic [15:0] gap_q, gap_d;
    logic [31:0] tmo_q, tmo_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] wdog_q, wdog_d;
    logic        pend_q, pend_d;
    logic [15:0] bursts_q, bursts_d;
    logic [15:0] ovf_q, ovf_d;
    logic        err_t_q, err_t_d;
    logic        err_c_q, err_c_d;
    logic        ctrl_q, ctrl_d;
    logic        busy_q, busy_d;
    logic        irq_q, irq_d;

    logic        start;
    logic        in_wd;
    logic        tmo_hit;
    logic [15:0] gap_len;
    logic        unused_stat;

    assign unused_stat = ^conv_stat[31:2];

    // The gap doubles as the converter clear time, so it is never shorter.
    assign gap_len = (gap_q > CLR_LEN) ? gap_q : CLR_LEN;
    assign start   = cfg_enable && !en_prev_q;
    assign in_wd   = (state_q == S_ARM) || (state_q == S_CAPTURE) || (state_q == S_DRAIN);
    assign tmo_hit = in_wd && (tmo_q != '0) && ((wdog_q + 32'd1) == tmo_q);

    always_comb begin
        state_d   = state_q;
        nb_d      = nb_q;
        nbursts_d = nbursts_q;
        gap_d     = gap_q;
        tmo_d     = tmo_q;
        cnt_d     = cnt_q;
        wdog_d    = in_wd ? wdog_q + 32'd1 : wdog_q;
        pend_d    = pend_q;
        bursts_d  = bursts_q;
        ovf_d     = ovf_q;
        err_t_d   = err_t_q;
        err_c_d   = err_c_q;

        if (((state_q == S_ARM) || (state_q == S_CAPTURE)) && conv_ovf && (ovf_q != '1)) begin
            ovf_d = ovf_q + 16'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    nb_d      = cfg_num_bytes;
                    nbursts_d = cfg_num_bursts;
                    gap_d     = cfg_gap_cycles;
                    tmo_d     = cfg_timeout;
                    bursts_d  = '0;
                    ovf_d     = '0;
                    err_t_d   = 1'b0;
                    err_c_d   = 1'b0;
                    pend_d    = 1'b0;
                    cnt_d     = '0;
                    if ((cfg_num_bytes == '0) || ((cfg_num_bytes % C_BYTES) != '0)) begin
                        err_c_d = 1'b1;
                        state_d = S_ERROR;
                    end else begin
                        state_d = S_CLEAR;
                    end
                end
            end
            S_CLEAR: begin
                wdog_d = '0;
                if (cnt_q == CLR_LEN - 16'd1) begin
                    cnt_d   = '0;
                    state_d = S_ARM;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_ARM: begin
                if (conv_stat[0]) state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                // Completion may beat done (or coincide with it); remember it.
                if (dma_cmplt) pend_d = 1'b1;
                if (conv_stat[1]) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (dma_cmplt || pend_q) begin
                    pend_d   = 1'b0;
                    bursts_d = bursts_q + 16'd1;
                    cnt_d    = '0;
                    if ((nbursts_q != '0) && ((bursts_q + 16'd1) == nbursts_q)) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (cnt_q == gap_len - 16'd1) begin
                    cnt_d   = '0;
                    wdog_d  = '0;
                    pend_d  = 1'b0;
                    state_d = S_ARM;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_DONE, S_ERROR: begin
                if (!cfg_enable) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Priority: abort over timeout over the normal progress above.
        if (tmo_hit) begin
            state_d  = S_ERROR;
            err_t_d  = 1'b1;
            bursts_d = bursts_q;
            pend_d   = pend_q;
        end
        if (!cfg_enable && (state_q inside {S_CLEAR, S_ARM, S_CAPTURE, S_DRAIN, S_GAP})) begin
            state_d  = S_IDLE;
            err_t_d  = err_t_q;
            bursts_d = bursts_q;
            pend_d   = 1'b0;
        end

        // Outputs are registered from the next state so they track state_q.
        ctrl_d = (state_d == S_ARM) || (state_d == S_CAPTURE) || (state_d == S_DRAIN);
        busy_d = state_d inside {S_CLEAR, S_ARM, S_CAPTURE, S_DRAIN, S_GAP};
        irq_d  = ((state_d == S_DONE) || (state_d == S_ERROR)) && (state_d != state_q);
    end

    always_ff @(posedge AXIS_ACLK or posedge AXIS_ARESET) begin
        if (AXIS_ARESET) begin
            state_q   <= S_IDLE;
            en_prev_q <= 1'b0;
            nb_q      <= '0;
            nbursts_q <= '0;
            gap_q     <= '0;
            tmo_q     <= '0;
            cnt_q     <= '0;
            wdog_q    <= '0;
            pend_q    <= 1'b0;
            bursts_q  <= '0;
            ovf_q     <= '0;
            err_t_q   <= 1'b0;
            err_c_q   <= 1'b0;
            ctrl_q    <= 1'b0;
            busy_q    <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            en_prev_q <= cfg_enable;
            nb_q      <= nb_d;
            nbursts_q <= nbursts_d;
            gap_q     <= gap_d;
            tmo_q     <= tmo_d;
            cnt_q     <= cnt_d;
            wdog_q    <= wdog_d;
            pend_q    <= pend_d;
            bursts_q  <= bursts_d;
            ovf_q     <= ovf_d;
            err_t_q   <= err_t_d;
            err_c_q   <= err_c_d;
            ctrl_q    <= ctrl_d;
            busy_q    <= busy_d;
            irq_q     <= irq_d;
        end
    end

    assign conv_ctrl      = {31'b0, ctrl_q};
    assign conv_num_bytes = nb_q;
    assign busy           = busy_q;
    assign irq            = irq_q;
    assign bursts_done    = bursts_q;
    assign ovf_count      = ovf_q;
    assign status         = {bursts_q, 10'b0, err_c_q, err_t_q, busy_q, state_q};

endmodule

// File: tb/tb_adi2axis_capture_seq.sv
// ---------------------------------------------------------------------------
// Bench for adi2axis_capture_seq. A small converter/DMA model answers
// conv_ctrl. On every state change the monitor pops the next expected event
// and checks it. Each event holds the state, its dwell in cycles since the
// previous change (or since the stimulus moved cfg_enable), the counters,
// the error bits and conv_num_bytes.
// ---------------------------------------------------------------------------
module tb_adi2axis_capture_seq;

    localparam logic [2:0] ST_IDLE = 3'd0, ST_CLEAR = 3'd1, ST_ARM = 3'd2, ST_CAP = 3'd3,
                           ST_DRAIN = 3'd4, ST_GAP = 3'd5, ST_DONE = 3'd6, ST_ERROR = 3'd7;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b0;
    logic [31:0] cfg_nb = '0;
    logic [15:0] cfg_bursts = '0;
    logic [15:0] cfg_gap = '0;
    logic [31:0] cfg_tmo = '0;
    logic [31:0] conv_ctrl, conv_num_bytes, conv_stat, status;
    logic        conv_ovf = 1'b0;
    logic        dma_cmplt, busy, irq;
    logic [15:0] bursts_done, ovf_count;

    // converter / DMA model
    logic       cap = 1'b0, done = 1'b0, nodone = 1'b0;
    logic [7:0] beats = '0, dcnt = '0, dma_dly = 8'd5;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int mark = 0;
    int irq_total = 0;
    int evn = 0;
    logic [3:0] prev_st = 4'hF;

    typedef struct {
        logic [2:0]  st;
        int          dwell;
        logic [15:0] bursts;
        logic [15:0] ovf;
        logic        errt;
        logic        errc;
        logic [31:0] nb;
    } exp_t;
    exp_t q[$];

    adi2axis_capture_seq #(.C_BYTES(8), .CLR_CYCLES(4)) dut (
        .AXIS_ACLK     (clk),
        .AXIS_ARESET   (rst),
        .cfg_enable    (en),
        .cfg_num_bytes (cfg_nb),
        .cfg_num_bursts(cfg_bursts),
        .cfg_gap_cycles(cfg_gap),
        .cfg_timeout   (cfg_tmo),
        .conv_ctrl     (conv_ctrl),
        .conv_num_bytes(conv_num_bytes),
        .conv_stat     (conv_stat),
        .conv_ovf      (conv_ovf),
        .dma_cmplt     (dma_cmplt),
        .busy          (busy),
        .irq           (irq),
        .bursts_done   (bursts_done),
        .ovf_count     (ovf_count),
        .status        (status)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Converter: capture_en one cycle after start, done after 8 beats.
    // DMA: completion pulse dma_dly cycles after done rises.
    always @(posedge clk) begin
        if (conv_ctrl[0] == 1'b0) begin
            cap   <= 1'b0;
            done  <= 1'b0;
            beats <= '0;
        end else if (!cap && !done) begin
            cap <= 1'b1;
        end else if (cap) begin
            beats <= beats + 8'd1;
            if (beats == 8'd7 && !nodone) begin
                cap  <= 1'b0;
                done <= 1'b1;
            end
        end
        if (!done) dcnt <= '0;
        else if (dcnt != 8'hFF) dcnt <= dcnt + 8'd1;
    end
    assign conv_stat = {30'b0, done, cap};
    assign dma_cmplt = done && (dcnt == dma_dly);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [2:0] st, input int dw, input int b, input int ov,
                        input bit et, input bit ec, input logic [31:0] nb);
        exp_t e;
        e.st = st; e.dwell = dw; e.bursts = 16'(b); e.ovf = 16'(ov);
        e.errt = et; e.errc = ec; e.nb = nb;
        q.push_back(e);
    endtask

    // monitor
    always @(negedge clk) begin
        exp_t e;
        logic xc, xb, xi;
        if (irq) irq_total++;
        if ({1'b0, status[2:0]} != prev_st) begin
            prev_st = {1'b0, status[2:0]};
            evn++;
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL ev%0d unexpected_state actual=%0d expected=none", evn, status[2:0]);
            end else begin
                e  = q.pop_front();
                xc = (e.st == ST_ARM) || (e.st == ST_CAP) || (e.st == ST_DRAIN);
                xb = (e.st >= ST_CLEAR) && (e.st <= ST_GAP);
                xi = (e.st == ST_DONE) || (e.st == ST_ERROR);
                chk($sformatf("ev%0d_state", evn), {29'b0, status[2:0]}, {29'b0, e.st});
                if (e.dwell >= 0) chk($sformatf("ev%0d_dwell", evn), cyc - mark, e.dwell);
                chk($sformatf("ev%0d_conv_ctrl", evn), conv_ctrl, {31'b0, xc});
                chk($sformatf("ev%0d_busy", evn), {31'b0, busy}, {31'b0, xb});
                chk($sformatf("ev%0d_irq", evn), {31'b0, irq}, {31'b0, xi});
                chk($sformatf("ev%0d_bursts_done", evn), {16'b0, bursts_done}, {16'b0, e.bursts});
                chk($sformatf("ev%0d_ovf_count", evn), {16'b0, ovf_count}, {16'b0, e.ovf});
                chk($sformatf("ev%0d_status", evn), status,
                    {e.bursts, 10'b0, e.errc, e.errt, xb, e.st});
                chk($sformatf("ev%0d_conv_num_bytes", evn), conv_num_bytes, e.nb);
            end
            mark = cyc;
        end
    end

    task automatic wait_empty(input int budget, input string nm);
        int n = 0;
        while (q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout actual=%0d_outstanding expected=0", nm, q.size());
            q.delete();
        end
    endtask

    task automatic drive_en(input logic v);
        @(negedge clk);
        en   = v;
        mark = cyc;
    endtask

    initial begin
        // 1: two bursts, gap 10, DMA 5 cycles after done; enable high at reset release
        cfg_nb = 32'd64; cfg_bursts = 16'd2; cfg_gap = 16'd10; cfg_tmo = '0;
        en = 1'b1;
        push(ST_IDLE, -1, 0, 0, 0, 0, 32'd0);
        push(ST_CLEAR, 1, 0, 0, 0, 0, 32'd64);
        push(ST_ARM,   4, 0, 0, 0, 0, 32'd64);
        push(ST_CAP,   2, 0, 0, 0, 0, 32'd64);
        push(ST_DRAIN, 8, 0, 0, 0, 0, 32'd64);
        push(ST_GAP,   5, 1, 0, 0, 0, 32'd64);
        push(ST_ARM,  10, 1, 0, 0, 0, 32'd64);
        push(ST_CAP,   2, 1, 0, 0, 0, 32'd64);
        push(ST_DRAIN, 8, 1, 0, 0, 0, 32'd64);
        push(ST_DONE,  5, 2, 0, 0, 0, 32'd64);
        repeat (3) @(negedge clk);
        rst  = 1'b0;
        mark = cyc;
        wait_empty(200, "run1");
        push(ST_IDLE, 1, 2, 0, 0, 0, 32'd64);
        drive_en(1'b0);
        wait_empty(20, "run1_ack");

        // 2: num_bytes not a multiple of 8
        cfg_nb = 32'd60; cfg_bursts = 16'd1;
        push(ST_ERROR, 1, 0, 0, 0, 1, 32'd60);
        drive_en(1'b1);
        wait_empty(20, "cfgerr");
        push(ST_IDLE, 1, 0, 0, 0, 1, 32'd60);
        drive_en(1'b0);
        wait_empty(20, "cfgerr_ack");

        // 3: converter never finishes, watchdog 100
        cfg_nb = 32'd64; cfg_tmo = 32'd100; nodone = 1'b1;
        push(ST_CLEAR, 1, 0, 0, 0, 0, 32'd64);
        push(ST_ARM,   4, 0, 0, 0, 0, 32'd64);
        push(ST_CAP,   2, 0, 0, 0, 0, 32'd64);
        push(ST_ERROR, 98, 0, 0, 1, 0, 32'd64);
        drive_en(1'b1);
        wait_empty(300, "timeout");
        push(ST_IDLE, 1, 0, 0, 1, 0, 32'd64);
        drive_en(1'b0);
        wait_empty(20, "timeout_ack");
        nodone = 1'b0; cfg_tmo = '0;

        // 4: continuous run, abort during burst 3 capture
        cfg_bursts = 16'd0;
        push(ST_CLEAR, 1, 0, 0, 0, 0, 32'd64);
        push(ST_ARM,   4, 0, 0, 0, 0, 32'd64);
        push(ST_CAP,   2, 0, 0, 0, 0, 32'd64);
        push(ST_DRAIN, 8, 0, 0, 0, 0, 32'd64);
        push(ST_GAP,   5, 1, 0, 0, 0, 32'd64);
        push(ST_ARM,  10, 1, 0, 0, 0, 32'd64);
        push(ST_CAP,   2, 1, 0, 0, 0, 32'd64);
        push(ST_DRAIN, 8, 1, 0, 0, 0, 32'd64);
        push(ST_GAP,   5, 2, 0, 0, 0, 32'd64);
        push(ST_ARM,  10, 2, 0, 0, 0, 32'd64);
        push(ST_CAP,   2, 2, 0, 0, 0, 32'd64);
        drive_en(1'b1);
        wait_empty(300, "abort_run");
        repeat (2) @(negedge clk);
        push(ST_IDLE, 1, 2, 0, 0, 0, 32'd64);
        drive_en(1'b0);
        wait_empty(20, "abort");

        // 5: DMA completion coincident with done, gap 0 -> 4-cycle gap
        cfg_bursts = 16'd2; cfg_gap = 16'd0; dma_dly = 8'd0;
        push(ST_CLEAR, 1, 0, 0, 0, 0, 32'd64);
        push(ST_ARM,   4, 0, 0, 0, 0, 32'd64);
        push(ST_CAP,   2, 0, 0, 0, 0, 32'd64);
        push(ST_DRAIN, 8, 0, 0, 0, 0, 32'd64);
        push(ST_GAP,   1, 1, 0, 0, 0, 32'd64);
        push(ST_ARM,   4, 1, 0, 0, 0, 32'd64);
        push(ST_CAP,   2, 1, 0, 0, 0, 32'd64);
        push(ST_DRAIN, 8, 1, 0, 0, 0, 32'd64);
        push(ST_DONE,  1, 2, 0, 0, 0, 32'd64);
        drive_en(1'b1);
        wait_empty(200, "coincident");
        push(ST_IDLE, 1, 2, 0, 0, 0, 32'd64);
        drive_en(1'b0);
        wait_empty(20, "coincident_ack");

        // 6: overflow held high through a 66000-cycle capture -> saturation
        cfg_bursts = 16'd1; cfg_tmo = 32'd66000; nodone = 1'b1; conv_ovf = 1'b1;
        dma_dly = 8'd5; cfg_gap = 16'd10;
        push(ST_CLEAR, 1, 0, 0, 0, 0, 32'd64);
        push(ST_ARM,   4, 0, 0, 0, 0, 32'd64);
        push(ST_CAP,   2, 0, 2, 0, 0, 32'd64);
        push(ST_ERROR, 65998, 0, 16'hFFFF, 1, 0, 32'd64);
        drive_en(1'b1);
        wait_empty(70000, "ovf_sat");
        push(ST_IDLE, 1, 0, 16'hFFFF, 1, 0, 32'd64);
        drive_en(1'b0);
        wait_empty(20, "ovf_ack");
        conv_ovf = 1'b0; nodone = 1'b0; cfg_tmo = '0;

        // 7: asynchronous reset during burst 2
        cfg_bursts = 16'd0;
        push(ST_CLEAR, 1, 0, 0, 0, 0, 32'd64);
        push(ST_ARM,   4, 0, 0, 0, 0, 32'd64);
        push(ST_CAP,   2, 0, 0, 0, 0, 32'd64);
        push(ST_DRAIN, 8, 0, 0, 0, 0, 32'd64);
        push(ST_GAP,   5, 1, 0, 0, 0, 32'd64);
        push(ST_ARM,  10, 1, 0, 0, 0, 32'd64);
        push(ST_CAP,   2, 1, 0, 0, 0, 32'd64);
        drive_en(1'b1);
        wait_empty(200, "reset_run");
        push(ST_IDLE, -1, 0, 0, 0, 0, 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        wait_empty(10, "async_reset");
        en = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        chk("irq_pulses", irq_total, 32'd5);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
